bot_update_fifo: RTL and testbench
==================================

BOT_UPDATE_FIFO -- requirements
Module: bot_update_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of 2, 2..64).
REQ-002 Parameter IRQ_THRESH, default 1, entry count at or above which irq asserts (1..DEPTH).
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 upd_sysregs  in  1  bot register-update indication, already in clk domain.
REQ-006 bot_info  in  32  snapshot word {LocX, LocY, Sensors, BotInfo}.
REQ-007 wb_adr_i  in  32  Wishbone address; only bits [7:0] decoded.
REQ-008 wb_dat_i  in  32  Wishbone write data.
REQ-009 wb_sel_i  in  4  byte selects; writes require wb_sel_i[0].
REQ-010 wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  Wishbone control.
REQ-011 wb_dat_o  out  32  registered read data.
REQ-012 wb_ack_o  out  1  registered acknowledge.
REQ-013 wb_err_o  out  1  tied 0.
REQ-014 irq  out  1  registered, level-high interrupt.

Function
REQ-015 Push trigger: rising edge of upd_sysregs (previous-cycle value 0, current value 1); a held-high level pushes once.
REQ-016 Push writes the current bot_info at the tail; count increments on the next clk edge.
REQ-017 Push when full and no pop in the same cycle: word dropped, overflow flag set (sticky), drop_cnt increments, saturating at 8'hFF.
REQ-018 wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o; every access completes in exactly one wait state.
REQ-019 wb_dat_o is updated on the same edge that asserts wb_ack_o and holds its value otherwise.
REQ-020 Read map, selected by wb_adr_i[7:0]:
- 0x00 DATA: head word; pops one entry on the ack edge when not empty; returns 32'h0 with no pop when empty.
- 0x04 STATUS: {16'h0, count[7:0], 5'h0, overflow, full, empty}.
- 0x08 CTRL: reads 32'h0.
- 0x0C DROPS: {24'h0, drop_cnt}.
- Unmapped offsets: return 32'h0.
REQ-021 A write to 0x08 with wb_sel_i[0] takes effect on the ack edge:
- bit0=1 clears overflow and drop_cnt.
- bit1=1 flushes the FIFO (pointers and count to 0).
- Writes to any other offset are acknowledged and ignored.
REQ-022 Push and pop in the same cycle when not empty, including full: both occur, count unchanged, no overflow.
REQ-023 Push and pop in the same cycle when empty: pop returns 32'h0, push stored, count becomes 1; no bypass.
REQ-024 Flush and push in the same cycle: flush wins, push discarded, drop_cnt unchanged.
REQ-025 Pointers wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-026 irq <= (count_next >= IRQ_THRESH) | overflow_next; irq deasserts the cycle after the condition clears.

Reset
REQ-027 Reset clears wb_dat_o=0, wb_ack_o=0, irq=0, count=0, both pointers=0, overflow=0, drop_cnt=0 and the edge-detect register=0.
REQ-028 Reset asserted mid-transfer aborts the transfer: no pop, no ack after reset release until a new cyc&stb; storage contents are don't-care.

Structure
REQ-029 Shared package bot_fifo_pkg holds: register offsets (0x00/0x04/0x08/0x0C), STATUS and CTRL bit positions, and the DEPTH default.
REQ-030 One sub-module, bot_update_ram: DEPTH x 32 register array with a synchronous write port and an asynchronous read port; all pointer, count and Wishbone logic stays in the top module.

Verification
REQ-031 Three upd_sysregs pulses with bot_info 0x11223344, 0x55667788, 0x99AABBCC -> STATUS count=3; three DATA reads return those words in order; then empty=1.
REQ-032 upd_sysregs held high for 10 cycles -> exactly one entry pushed.
REQ-033 Ten pushes with DEPTH=8 -> full=1, overflow=1, DROPS=2, irq=1; CTRL write 0x1 -> overflow=0, DROPS=0; full stays 1.
REQ-034 FIFO full and a push coincident with a DATA read ack -> count stays 8, overflow stays 0, oldest word returned.
REQ-035 DATA read when empty -> 32'h0, count 0; CTRL write 0x2 with 5 entries and a simultaneous push -> count=0, irq=0 on the next cycle.
REQ-036 reset pulsed during an active cyc&stb -> all outputs 0, and the next access acks one cycle after cyc&stb.

Source files
------------

// File: rtl/bot_fifo_pkg.sv
// Shared constants for the bot update FIFO: register map, bit positions, defaults.
package bot_fifo_pkg;

    localparam int unsigned DEPTH_DEFAULT = 8;

    // Wishbone register offsets (decoded from wb_adr_i[7:0])
    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_DROPS  = 8'h0C;

    // STATUS bit positions
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;

    // CTRL bit positions
    localparam int unsigned CTRL_CLR_BIT   = 0;
    localparam int unsigned CTRL_FLUSH_BIT = 1;

    // Build the STATUS word from its fields
    function automatic logic [31:0] pack_status(input logic [7:0] cnt,
                                                input logic ovf,
                                                input logic full,
                                                input logic empty);
        pack_status = {16'h0000, cnt, 5'b00000, ovf, full, empty};
    endfunction

endpackage

// File: rtl/bot_update_ram.sv
// DEPTH x 32 storage: synchronous write port, asynchronous read port, no reset.
module bot_update_ram
    import bot_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    // Write the snapshot word into the addressed slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bot_update_fifo.sv
// Bot register-update snapshot FIFO with a Wishbone slave and level interrupt.
module bot_update_fifo
    import bot_fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEFAULT,
    parameter int unsigned IRQ_THRESH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_sysregs,
    input  logic [31:0] bot_info,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_IRQ = CW'(IRQ_THRESH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;
    logic          upd_prev_q, upd_prev_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic          irq_q, irq_d;

    logic          empty_s, full_s, acc_s, push_s, pop_s, push_ok_s, drop_s;
    logic          ctrl_wr_s, flush_s, clr_s, ram_we_s;
    logic [7:0]    adr_s;
    logic [7:0]    cnt8_s;
    logic [31:0]   ram_rdata_s;
    logic          unused_s;

    assign empty_s   = (count_q == {CW{1'b0}});
    assign full_s    = (count_q == CNT_MAX);
    assign adr_s     = wb_adr_i[7:0];
    assign cnt8_s    = 8'(count_q);
    // Access is serviced on the edge that raises ack
    assign acc_s     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign push_s    = upd_sysregs & ~upd_prev_q;
    assign pop_s     = acc_s & ~wb_we_i & (adr_s == ADDR_DATA) & ~empty_s;
    assign ctrl_wr_s = acc_s & wb_we_i & wb_sel_i[0] & (adr_s == ADDR_CTRL);
    assign flush_s   = ctrl_wr_s & wb_dat_i[CTRL_FLUSH_BIT];
    assign clr_s     = ctrl_wr_s & wb_dat_i[CTRL_CLR_BIT];
    // A full FIFO still accepts a push when a pop frees a slot on the same edge
    assign push_ok_s = push_s & (~full_s | pop_s) & ~flush_s;
    assign drop_s    = push_s & full_s & ~pop_s & ~flush_s;
    assign ram_we_s  = push_ok_s;
    assign unused_s  = ^{wb_adr_i[31:8], wb_sel_i[3:1], wb_dat_i[31:2]};

    bot_update_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_ptr_q),
        .wdata (bot_info),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata_s)
    );

    // Next-state for pointers, count, overflow and drop counter
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        upd_prev_d = upd_sysregs;
        if (flush_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
        if (clr_s) begin
            ovf_d  = 1'b0;
            drop_d = 8'h00;
        end else if (drop_s) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'h01;
            end else begin
                drop_d = drop_q;
            end
        end else begin
            ovf_d  = ovf_q;
            drop_d = drop_q;
        end
    end

    // Next-state for Wishbone response and interrupt
    always_comb begin
        ack_d = wb_cyc_i & wb_stb_i & ~ack_q;
        dat_d = dat_q;
        if (acc_s && !wb_we_i) begin
            case (adr_s)
                ADDR_DATA:   dat_d = empty_s ? 32'h0000_0000 : ram_rdata_s;
                ADDR_STATUS: dat_d = pack_status(cnt8_s, ovf_q, full_s, empty_s);
                ADDR_CTRL:   dat_d = 32'h0000_0000;
                ADDR_DROPS:  dat_d = {24'h00_0000, drop_q};
                default:     dat_d = 32'h0000_0000;
            endcase
        end else begin
            dat_d = dat_q;
        end
        irq_d = (count_d >= CNT_IRQ) | ovf_d;
    end

    // State registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            ovf_q      <= 1'b0;
            drop_q     <= 8'h00;
            upd_prev_q <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0000_0000;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            upd_prev_q <= upd_prev_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = 1'b0;
    assign irq      = irq_q;

endmodule

// File: tb/tb_bot_update_fifo.sv
// Directed testbench for bot_update_fifo (DEPTH=8, IRQ_THRESH=1).
module tb_bot_update_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_sysregs = 1'b0;
    logic [31:0] bot_info = 32'h0;
    logic [31:0] wb_adr_i = 32'h0;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rd;

    bot_update_fifo #(.DEPTH(8), .IRQ_THRESH(1)) dut (
        .clk(clk), .reset(reset), .upd_sysregs(upd_sysregs), .bot_info(bot_info),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One Wishbone access; optionally raise upd_sysregs in the same cycle
    task automatic wb_access(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                             input logic push, input logic [31:0] pval,
                             output logic [31:0] rdat);
        int k;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = {24'h0, adr}; wb_dat_i = wdat; wb_sel_i = 4'hF;
        if (push) begin upd_sysregs = 1'b1; bot_info = pval; end
        @(negedge clk);
        upd_sysregs = 1'b0;
        k = 0;
        while (!wb_ack_o && k < 4) begin @(negedge clk); k++; end
        if (!wb_ack_o) check_val("ack_timeout", {31'h0, wb_ack_o}, 32'h1);
        rdat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] v);
        @(negedge clk);
        upd_sysregs = 1'b1; bot_info = v;
        @(negedge clk);
        upd_sysregs = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_dat", wb_dat_o, 32'h0);
        check_val("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        check_val("rst_irq", {31'h0, irq}, 32'h0);
        check_val("rst_err", {31'h0, wb_err_o}, 32'h0);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("rst_status", rd, 32'h0000_0001);

        // three pushes then ordered reads
        push_word(32'h1122_3344);
        push_word(32'h5566_7788);
        push_word(32'h99AA_BBCC);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("status_cnt3", rd, 32'h0000_0300);
        check_val("irq_cnt3", {31'h0, irq}, 32'h1);
        wb_access(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, rd);
        check_val("data0", rd, 32'h1122_3344);
        wb_access(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, rd);
        check_val("data1", rd, 32'h5566_7788);
        wb_access(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, rd);
        check_val("data2", rd, 32'h99AA_BBCC);
        check_val("irq_drained", {31'h0, irq}, 32'h0);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("status_empty", rd, 32'h0000_0001);

        // held level pushes once
        @(negedge clk);
        upd_sysregs = 1'b1; bot_info = 32'hDEAD_BEEF;
        repeat (10) @(negedge clk);
        upd_sysregs = 1'b0;
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("held_status", rd, 32'h0000_0100);
        wb_access(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, rd);
        check_val("held_data", rd, 32'hDEAD_BEEF);

        // overflow: ten pushes into eight slots
        for (int i = 0; i < 10; i++) push_word(32'hA0 + i);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("ovf_status", rd, 32'h0000_0806);
        wb_access(1'b0, 8'h0C, 32'h0, 1'b0, 32'h0, rd);
        check_val("ovf_drops", rd, 32'h0000_0002);
        check_val("ovf_irq", {31'h0, irq}, 32'h1);
        wb_access(1'b0, 8'h08, 32'h0, 1'b0, 32'h0, rd);
        check_val("ctrl_read", rd, 32'h0);
        wb_access(1'b1, 8'h08, 32'h1, 1'b0, 32'h0, rd);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("clr_status", rd, 32'h0000_0802);
        wb_access(1'b0, 8'h0C, 32'h0, 1'b0, 32'h0, rd);
        check_val("clr_drops", rd, 32'h0);

        // full: push coincident with pop
        wb_access(1'b0, 8'h00, 32'h0, 1'b1, 32'h0000_00B0, rd);
        check_val("fullpp_data", rd, 32'h0000_00A0);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("fullpp_status", rd, 32'h0000_0802);
        for (int i = 1; i < 8; i++) begin
            wb_access(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, rd);
            check_val("drain", rd, 32'hA0 + i);
        end
        wb_access(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, rd);
        check_val("drain_last", rd, 32'h0000_00B0);

        // empty read, and empty read with push (no bypass)
        wb_access(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, rd);
        check_val("empty_data", rd, 32'h0);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("empty_status", rd, 32'h0000_0001);
        wb_access(1'b0, 8'h00, 32'h0, 1'b1, 32'hCAFE_0001, rd);
        check_val("nobypass_data", rd, 32'h0);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("nobypass_status", rd, 32'h0000_0100);
        wb_access(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, rd);
        check_val("nobypass_pop", rd, 32'hCAFE_0001);

        // flush with a coincident push; write to other offset ignored
        for (int i = 0; i < 5; i++) push_word(32'hC0 + i);
        wb_access(1'b1, 8'h04, 32'h3, 1'b0, 32'h0, rd);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("ignored_wr", rd, 32'h0000_0500);
        wb_access(1'b1, 8'h08, 32'h2, 1'b1, 32'hFFFF_0000, rd);
        check_val("flush_irq", {31'h0, irq}, 32'h0);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        check_val("flush_status", rd, 32'h0000_0001);
        wb_access(1'b0, 8'h0C, 32'h0, 1'b0, 32'h0, rd);
        check_val("flush_drops", rd, 32'h0);

        // reset during an active access
        push_word(32'h1);
        push_word(32'h2);
        wb_access(1'b0, 8'h04, 32'h0, 1'b0, 32'h0, rd);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
        #1 reset = 1'b1;
        #1;
        check_val("midrst_dat", wb_dat_o, 32'h0);
        check_val("midrst_ack", {31'h0, wb_ack_o}, 32'h0);
        check_val("midrst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        check_val("postrst_noack", {31'h0, wb_ack_o}, 32'h0);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h4;
        @(negedge clk);
        check_val("postrst_ack", {31'h0, wb_ack_o}, 32'h1);
        check_val("postrst_status", wb_dat_o, 32'h0000_0001);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        check_val("ack_drop", {31'h0, wb_ack_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
